fp_op_dispatcher: RTL and testbench

Operand issue stage that sits directly upstream of the floating-point add/sub unit.
- Buffers (op, a, b) requests in a small FIFO.
- Drives the unit's start/op/data_a/data_b inputs and holds them stable for the whole operation.
- Waits for the unit's ready, captures data_o, and presents it on a valid/ack result port.
- Isolates the unit's single-shot handshake from bursty producers and slow consumers.

---
 rtl/fp_op_dispatcher.sv | 194 +++++++++++++++++++
 tb/tb_fp_op_dispatcher.sv | 374 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_op_dispatcher.sv
// fp_op_dispatcher: operand FIFO and single-shot issue FSM in front of the FP add/sub unit.
// Optional FP_DISPATCH_ZERO_SHORTCUT_EN resolves +/-0 operands without using the unit.
module fp_op_dispatcher #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_op,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  output logic        fpu_start,
  output logic        fpu_op,
  output logic [31:0] fpu_a,
  output logic [31:0] fpu_b,
  input  logic        fpu_busy,
  input  logic        fpu_ready,
  input  logic [31:0] fpu_data,
  output logic        res_valid,
  output logic [31:0] res_data,
  input  logic        res_ack,
  output logic        timeout_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } state_t;

  state_t state, state_nx;

  logic [64:0]   mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [CW-1:0] count;
  logic [TW-1:0] tcnt;

  logic        full, empty, push, pop;
  logic        head_op;
  logic [31:0] head_a, head_b;
  logic        can_go, tmo_hit;
  logic        load, zload, cap_fpu, tmo;
  logic        zero_hit;
  logic [31:0] zero_res;
  logic        unused_busy;

  assign unused_busy = fpu_busy;
  assign full        = count == CW'(DEPTH);
  assign empty       = count == '0;
  assign in_ready    = !full;
  assign push        = in_valid && !full;
  assign {head_op, head_a, head_b} = mem[rptr];
  assign can_go      = !empty && !res_valid;
  assign tmo_hit     = tcnt == TW'(TIMEOUT - 1);

`ifdef FP_DISPATCH_ZERO_SHORTCUT_EN
  logic a_zero, b_zero;
  assign a_zero   = head_a[30:0] == 31'd0;
  assign b_zero   = head_b[30:0] == 31'd0;
  assign zero_hit = a_zero || b_zero;

  always_comb begin
    zero_res = 32'h0000_0000;
    if (a_zero && b_zero)
      zero_res = 32'h0000_0000;
    else if (b_zero)
      zero_res = head_a;
    else if (head_op)
      zero_res = {~head_b[31], head_b[30:0]};
    else
      zero_res = head_b;
  end
`else
  assign zero_hit = 1'b0;
  assign zero_res = 32'h0000_0000;
`endif

  always_ff @(posedge clock) begin
    if (push)
      mem[wptr] <= {in_op, in_a, in_b};
  end

  // head stays in place until its result is captured
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push)
        wptr <= wptr + AW'(1);
      if (pop)
        rptr <= rptr + AW'(1);
      unique case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      state <= S_IDLE;
    else
      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE: begin
        if (can_go)
          state_nx = zero_hit ? S_DONE : S_ISSUE;
      end
      S_ISSUE:
        state_nx = S_WAIT;
      S_WAIT: begin
        if (fpu_ready || tmo_hit)
          state_nx = S_DONE;
      end
      S_DONE: begin
        if (res_ack)
          state_nx = S_IDLE;
      end
      default:
        state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    fpu_start = 1'b0;
    load      = 1'b0;
    zload     = 1'b0;
    cap_fpu   = 1'b0;
    tmo       = 1'b0;
    unique case (state)
      S_IDLE: begin
        load  = can_go && !zero_hit;
        zload = can_go && zero_hit;
      end
      S_ISSUE:
        fpu_start = 1'b1;
      S_WAIT: begin
        cap_fpu = fpu_ready;
        tmo     = !fpu_ready && tmo_hit;
      end
      default: ;
    endcase
    pop = cap_fpu || tmo || zload;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fpu_op      <= 1'b0;
      fpu_a       <= '0;
      fpu_b       <= '0;
      tcnt        <= '0;
      res_valid   <= 1'b0;
      res_data    <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (load) begin
        fpu_op <= head_op;
        fpu_a  <= head_a;
        fpu_b  <= head_b;
      end
      if (state == S_ISSUE)
        tcnt <= '0;
      else if (state == S_WAIT)
        tcnt <= tcnt + TW'(1);
      if (cap_fpu)
        res_data <= fpu_data;
      else if (tmo)
        res_data <= 32'h7FC0_0000;
      else if (zload)
        res_data <= zero_res;
      if (pop)
        res_valid <= 1'b1;
      else if (state == S_DONE && res_ack)
        res_valid <= 1'b0;
      if (tmo)
        timeout_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fp_op_dispatcher.sv
// tb_fp_op_dispatcher: directed + random checks of fp_op_dispatcher
// against a behavioural FP unit and a result-order scoreboard.
module tb_fp_op_dispatcher;

  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 64;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        in_op = 1'b0;
  logic [31:0] in_a = '0;
  logic [31:0] in_b = '0;
  logic        fpu_start;
  logic        fpu_op;
  logic [31:0] fpu_a;
  logic [31:0] fpu_b;
  logic        fpu_busy;
  logic        fpu_ready;
  logic [31:0] fpu_data;
  logic        res_valid;
  logic [31:0] res_data;
  logic        res_ack = 1'b0;
  logic        timeout_err;

  always #5 clock = ~clock;

  fp_op_dispatcher #(
    .DEPTH   (DEPTH),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_op       (in_op),
    .in_a        (in_a),
    .in_b        (in_b),
    .fpu_start   (fpu_start),
    .fpu_op      (fpu_op),
    .fpu_a       (fpu_a),
    .fpu_b       (fpu_b),
    .fpu_busy    (fpu_busy),
    .fpu_ready   (fpu_ready),
    .fpu_data    (fpu_data),
    .res_valid   (res_valid),
    .res_data    (res_data),
    .res_ack     (res_ack),
    .timeout_err (timeout_err)
  );

  // Behavioural FP unit: ready N cycles after the start pulse.
  function automatic logic [31:0] fp_result(input logic op,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
    if (!op && a == 32'h3F80_0000 && b == 32'h4000_0000)
      return 32'h4040_0000;
    return (a ^ {b[15:0], b[31:16]}) + {31'b0, op} + 32'h0000_1234;
  endfunction

  logic        m_act = 1'b0;
  int          m_left = 0;
  logic        m_op = 1'b0;
  logic [31:0] m_a = '0;
  logic [31:0] m_b = '0;
  logic        m_never = 1'b0;
  logic        rand_lat = 1'b0;
  int          fp_lat = 4;
  logic        force_rdy = 1'b0;
  int          n_starts = 0;

  assign fpu_ready = (m_act && m_left == 1) || force_rdy;
  assign fpu_busy  = m_act;
  assign fpu_data  = fp_result(m_op, m_a, m_b);

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_act  <= 1'b0;
      m_left <= 0;
    end else if (fpu_start) begin
      m_act  <= 1'b1;
      m_op   <= fpu_op;
      m_a    <= fpu_a;
      m_b    <= fpu_b;
      m_left <= m_never ? 0 :
                (rand_lat ? int'($urandom_range(12, 1)) : fp_lat);
    end else if (m_act) begin
      if (m_left == 1)
        m_act <= 1'b0;
      else if (m_left != 0)
        m_left <= m_left - 1;
    end
  end

  always @(posedge clock) begin
    if (fpu_start)
      n_starts <= n_starts + 1;
  end

  // Expected result of a request, from the dispatcher's rules.
  function automatic logic [31:0] expect_of(input logic op,
                                            input logic [31:0] a,
                                            input logic [31:0] b,
                                            input logic never);
`ifdef FP_DISPATCH_ZERO_SHORTCUT_EN
    if (a[30:0] == 31'd0 && b[30:0] == 31'd0) return 32'h0000_0000;
    if (b[30:0] == 31'd0) return a;
    if (a[30:0] == 31'd0) return op ? {~b[31], b[30:0]} : b;
`endif
    if (never) return 32'h7FC0_0000;
    return fp_result(op, a, b);
  endfunction

  int          errors = 0;
  int          checks = 0;
  logic [31:0] exp_q [$];

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clock);
  endtask

  task automatic send(input logic op, input logic [31:0] a,
                      input logic [31:0] b);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_op = op;
    in_a = a;
    in_b = b;
    while (!in_ready && n < 300) begin
      tick();
      n++;
    end
    chk("send_ready", 32'(in_ready), 32'd1);
    if (in_ready)
      exp_q.push_back(expect_of(op, a, b, m_never));
    tick();
    in_valid = 1'b0;
  endtask

  task automatic take(input string tag);
    int n;
    logic [31:0] e;
    n = 0;
    res_ack = 1'b0;
    while (!res_valid && n < 300) begin
      tick();
      n++;
    end
    chk({tag, "_valid"}, 32'(res_valid), 32'd1);
    e = 32'hDEAD_BEEF;
    if (exp_q.size() > 0)
      e = exp_q.pop_front();
    chk(tag, res_data, e);
    res_ack = 1'b1;
    tick();
    res_ack = 1'b0;
    chk({tag, "_clr"}, 32'(res_valid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  int          n, bad, s0;
  logic [31:0] r, ra, rb;
  logic        rop;

  initial begin
    #1 reset = 1'b1;
    tick();
    tick();
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_start", 32'(fpu_start), 32'd0);
    chk("rst_tmo", 32'(timeout_err), 32'd0);
    chk("rst_fpu_a", fpu_a, 32'd0);
    chk("rst_res_data", res_data, 32'd0);
    reset = 1'b0;

    // single add, latency 4
    fp_lat = 4;
    s0 = n_starts;
    in_valid = 1'b1;
    in_op = 1'b0;
    in_a = 32'h3F80_0000;
    in_b = 32'h4000_0000;
    chk("t1_ready", 32'(in_ready), 32'd1);
    exp_q.push_back(32'h4040_0000);
    tick();
    in_valid = 1'b0;
    chk("t1_c1_start", 32'(fpu_start), 32'd0);
    tick();
    chk("t1_c2_start", 32'(fpu_start), 32'd1);
    n = 0;
    bad = 0;
    while (!res_valid && n < 50) begin
      tick();
      n++;
      if ({fpu_op, fpu_a, fpu_b} !== {1'b0, 32'h3F80_0000, 32'h4000_0000})
        bad++;
    end
    chk("t1_latency", 32'(n), 32'd5);
    chk("t1_ops_stable", 32'(bad), 32'd0);
    chk("t1_one_start", 32'(n_starts - s0), 32'd1);
    chk("t1_res_data", res_data, 32'h4040_0000);
    repeat (3) tick();
    chk("t1_hold_valid", 32'(res_valid), 32'd1);
    take("t1_res");

    // fill FIFO with the unit stalled
    fp_lat = 30;
    for (int i = 0; i < 4; i++)
      send(1'(i), 32'h4100_0000 + 32'(i), 32'h3F00_0000 + 32'(i));
    chk("t2_full", 32'(in_ready), 32'd0);
    in_valid = 1'b1;
    in_op = 1'b1;
    in_a = 32'h4200_0000;
    in_b = 32'h3F80_0000;
    n = 0;
    while (!in_ready && n < 200) begin
      tick();
      n++;
    end
    chk("t2_free_on_capture", 32'(res_valid), 32'd1);
    exp_q.push_back(expect_of(1'b1, 32'h4200_0000, 32'h3F80_0000, 1'b0));
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++)
      take("t2_order");

    // timeout
    m_never = 1'b1;
    send(1'b0, 32'h4080_0000, 32'h40A0_0000);
    n = 0;
    while (!fpu_start && n < 20) begin
      tick();
      n++;
    end
    chk("t3_start", 32'(fpu_start), 32'd1);
    n = 0;
    while (!res_valid && n < 200) begin
      tick();
      n++;
    end
    chk("t3_latency", 32'(n), 32'd65);
    chk("t3_nan", res_data, 32'h7FC0_0000);
    chk("t3_err", 32'(timeout_err), 32'd1);
    take("t3_res");
    m_never = 1'b0;
    fp_lat = 3;
    send(1'b1, 32'h4080_0000, 32'h3F80_0000);
    take("t3_next");
    chk("t3_sticky", 32'(timeout_err), 32'd1);

    // consumer holds off ack
    fp_lat = 2;
    send(1'b0, 32'h4110_0000, 32'h4120_0000);
    send(1'b1, 32'h4130_0000, 32'h4140_0000);
    send(1'b0, 32'h4150_0000, 32'h4160_0000);
    n = 0;
    while (!res_valid && n < 50) begin
      tick();
      n++;
    end
    r = res_data;
    s0 = n_starts;
    bad = 0;
    repeat (20) begin
      tick();
      if (res_data !== r || res_valid !== 1'b1)
        bad++;
    end
    chk("t4_held", 32'(bad), 32'd0);
    chk("t4_no_start", 32'(n_starts - s0), 32'd0);
    for (int i = 0; i < 3; i++)
      take("t4_res");

    // async reset mid-WAIT
    fp_lat = 20;
    send(1'b0, 32'h4040_0000, 32'h4040_0000);
    n = 0;
    while (!fpu_start && n < 20) begin
      tick();
      n++;
    end
    tick();
    tick();
    tick();
    #2 reset = 1'b1;
    #1;
    chk("t5_start", 32'(fpu_start), 32'd0);
    chk("t5_in_ready", 32'(in_ready), 32'd1);
    chk("t5_res_valid", 32'(res_valid), 32'd0);
    chk("t5_fpu_a", fpu_a, 32'd0);
    chk("t5_fpu_b", fpu_b, 32'd0);
    chk("t5_tmo_clr", 32'(timeout_err), 32'd0);
    exp_q.delete();
    tick();
    reset = 1'b0;
    force_rdy = 1'b1;
    tick();
    tick();
    force_rdy = 1'b0;
    s0 = n_starts;
    repeat (5) tick();
    chk("t5_late_ready", 32'(res_valid), 32'd0);
    chk("t5_empty", 32'(n_starts - s0), 32'd0);

    // zero operand
    fp_lat = 3;
    s0 = n_starts;
    send(1'b1, 32'h0000_0000, 32'h4000_0000);
    take("t6_zero");
`ifdef FP_DISPATCH_ZERO_SHORTCUT_EN
    chk("t6_starts", 32'(n_starts - s0), 32'd0);
`else
    chk("t6_starts", 32'(n_starts - s0), 32'd1);
`endif

    // random traffic
    rand_lat = 1'b1;
    for (int c = 0; c < 400; c++) begin
      rop = 1'($urandom);
      ra = ($urandom_range(3, 0) == 0) ? ($urandom & 32'h8000_0000) : $urandom;
      rb = ($urandom_range(3, 0) == 0) ? ($urandom & 32'h8000_0000) : $urandom;
      in_valid = 1'($urandom);
      in_op = rop;
      in_a = ra;
      in_b = rb;
      res_ack = 1'($urandom);
      if (in_valid && in_ready)
        exp_q.push_back(expect_of(rop, ra, rb, 1'b0));
      if (res_valid && res_ack) begin
        r = 32'hDEAD_BEEF;
        if (exp_q.size() > 0)
          r = exp_q.pop_front();
        chk("rnd_res", res_data, r);
      end
      if (fpu_start)
        chk("rnd_start_excl", 32'(res_valid), 32'd0);
      tick();
    end
    in_valid = 1'b0;
    res_ack = 1'b1;
    n = 0;
    while (exp_q.size() > 0 && n < 2000) begin
      if (res_valid) begin
        r = exp_q.pop_front();
        chk("drain_res", res_data, r);
      end
      tick();
      n++;
    end
    chk("drain_empty", 32'(exp_q.size()), 32'd0);
    res_ack = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
